// File: rtl/fifo_display_reader_if.sv
// FIFO read port shared by the display reader and a show-ahead FIFO.
interface fifo_display_reader_if #(
    parameter int DATA_W = 16
);
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_en;

    // Reader side: pops the FIFO and consumes its head word.
    modport master (
        output rd_en,
        input  rd_valid,
        input  rd_data
    );

    // FIFO side: presents the head word and accepts pop strobes.
    modport slave (
        input  rd_en,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/fifo_display_reader.sv
// Pops one FIFO word per pop-button press and shows the last popped word
// as four hex digits on a time-multiplexed seven-segment display.
module fifo_display_reader #(
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pop_btn,
    fifo_display_reader_if.master fifo,
    output logic [3:0]            an,
    output logic [6:0]            seg,
    output logic                  empty_err
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_POP  = 1'b1
    } state_t;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    logic              sync1_r, sync2_r, sync3_r;
    logic              press_s;
    state_t            state_r, state_nxt_s;
    logic              rd_en_nxt_s, capture_s, err_set_s, err_clr_s;
    logic              rd_en_r, empty_err_r, loaded_r;
    logic [DATA_W-1:0] shown_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        idx_r;
    logic              wrap_s;
    logic [3:0]        nibble_s;
    logic [3:0]        an_r;
    logic [6:0]        seg_r;

    // Bring the asynchronous button into the clock domain and keep one
    // extra delayed copy for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= pop_btn;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign press_s = sync2_r & ~sync3_r;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: a press with data pending starts a pop; a pop lasts one cycle.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (press_s && fifo.rd_valid) begin
                    state_nxt_s = ST_POP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_POP:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: strobe/capture while popping, flag presses on an empty FIFO.
    always_comb begin
        rd_en_nxt_s = 1'b0;
        capture_s   = 1'b0;
        err_set_s   = 1'b0;
        err_clr_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (press_s && !fifo.rd_valid) begin
                    err_set_s = 1'b1;
                end else begin
                    err_set_s = 1'b0;
                end
            end
            ST_POP: begin
                rd_en_nxt_s = 1'b1;
                capture_s   = 1'b1;
                err_clr_s   = 1'b1;
            end
            default: begin
                rd_en_nxt_s = 1'b0;
                capture_s   = 1'b0;
            end
        endcase
    end

    // Registered pop strobe, captured word and sticky empty flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_en_r     <= 1'b0;
            shown_r     <= '0;
            loaded_r    <= 1'b0;
            empty_err_r <= 1'b0;
        end else begin
            rd_en_r <= rd_en_nxt_s;
            if (capture_s) begin
                shown_r  <= fifo.rd_data;
                loaded_r <= 1'b1;
            end
            if (err_set_s) begin
                empty_err_r <= 1'b1;
            end else if (err_clr_s) begin
                empty_err_r <= 1'b0;
            end
        end
    end

    assign wrap_s   = (cnt_r == CNT_W'(REFRESH_DIV - 1));
    assign nibble_s = shown_r[{idx_r, 2'b00} +: 4];

    // Free-running digit scan; pops never disturb its phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
            idx_r <= 2'd0;
        end else if (wrap_s) begin
            cnt_r <= '0;
            idx_r <= idx_r + 2'd1;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Anode and segment drive registered together so they switch on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_r  <= 4'b1111;
            seg_r <= 7'b1111111;
        end else if (loaded_r) begin
            an_r  <= ~(4'b0001 << idx_r);
            seg_r <= hex7(nibble_s);
        end else begin
            an_r  <= 4'b1111;
            seg_r <= 7'b1111111;
        end
    end

    assign fifo.rd_en = rd_en_r;
    assign an         = an_r;
    assign seg        = seg_r;
    assign empty_err  = empty_err_r;

endmodule
